// File: rtl/ppg_pkg.sv
// Shared types and constants for the PPG LED/ADC scheduler.
// DARK_PHASE_EN adds the ambient-light states to the state enum.
package ppg_pkg;

  localparam int unsigned ADC_W    = 8;
  localparam int unsigned SETTLE_W = 4;

  localparam logic CH_RED = 1'b0;
  localparam logic CH_IR  = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StRedSettle,
    StRedSample,
    StRedPush,
    StIrSettle,
    StIrSample,
    StIrPush
`ifdef DARK_PHASE_EN
    ,
    StDarkSettle,
    StDarkSample
`endif
  } state_e;

  // A settle request of zero still takes one clock.
  function automatic logic [SETTLE_W-1:0] settle_len(input logic [SETTLE_W-1:0] s);
    return (s == '0) ? SETTLE_W'(1) : s;
  endfunction

endpackage

// File: rtl/ppg_sample_pusher.sv
// Valid/ready handshake toward the shared FIR with a bounded wait; a sample
// that is not accepted within MaxWait clocks is dropped.
module ppg_sample_pusher
  import ppg_pkg::*;
#(
  parameter int unsigned MaxWait = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [ADC_W-1:0] load_data_i,
  input  logic             load_ch_i,
  input  logic             fir_ready_i,
  output logic             fir_valid_o,
  output logic [ADC_W-1:0] fir_data_o,
  output logic             fir_ch_o,
  output logic             done_o,
  output logic             drop_o
);

  localparam int unsigned CntW = (MaxWait > 1) ? $clog2(MaxWait) : 1;

  logic             valid_q, valid_d;
  logic [ADC_W-1:0] data_q, data_d;
  logic             ch_q, ch_d;
  logic [CntW-1:0]  wait_q, wait_d;
  logic             timeout;

  assign timeout = valid_q & ~fir_ready_i & (wait_q == CntW'(MaxWait - 1));

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    wait_d  = wait_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
      ch_d    = load_ch_i;
      wait_d  = '0;
    end else if (valid_q) begin
      if (fir_ready_i || timeout) begin
        valid_d = 1'b0;
        wait_d  = '0;
      end else begin
        wait_d = wait_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= 1'b0;
      wait_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      wait_q  <= wait_d;
    end
  end

  assign fir_valid_o = valid_q;
  assign fir_data_o  = data_q;
  assign fir_ch_o    = ch_q;
  assign done_o      = valid_q & (fir_ready_i | timeout);
  assign drop_o      = timeout;

endmodule

// File: rtl/led_adc_scheduler.sv
// Time-multiplexes RED/IR LEDs, samples the ADC per channel and offers each
// sample to a shared FIR. Optional macro DARK_PHASE_EN adds ambient subtraction.
module led_adc_scheduler
  import ppg_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [ADC_W-1:0]    adc,
  input  logic                fir_ready,
  output logic                led_red,
  output logic                led_ir,
  output logic                fir_valid,
  output logic [ADC_W-1:0]    fir_data,
  output logic                fir_ch,
  output logic [ADC_W-1:0]    red_sample,
  output logic [ADC_W-1:0]    ir_sample,
  output logic                frame_done,
  output logic                overrun
);

`ifdef DARK_PHASE_EN
  localparam state_e FrameStart = StDarkSettle;
`else
  localparam state_e FrameStart = StRedSettle;
`endif

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [ADC_W-1:0]    red_q, red_d, ir_q, ir_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;
  logic [ADC_W-1:0]    sample_val;
  logic                load, load_ch, push_done, push_drop;
  logic [SETTLE_W-1:0] settle_init;

  assign settle_init = settle_len(settle_cycles) - SETTLE_W'(1);

`ifdef DARK_PHASE_EN
  logic [ADC_W-1:0] dark_q, dark_d;
  assign sample_val = (adc > dark_q) ? adc - dark_q : '0;
`else
  assign sample_val = adc;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    red_d        = red_q;
    ir_d         = ir_q;
    load         = 1'b0;
    load_ch      = CH_RED;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q | push_drop;
`ifdef DARK_PHASE_EN
    dark_d       = dark_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = FrameStart;
          cnt_d   = settle_init;
        end
      end
`ifdef DARK_PHASE_EN
      StDarkSettle: begin
        if (cnt_q == '0) state_d = StDarkSample;
        else cnt_d = cnt_q - SETTLE_W'(1);
      end
      StDarkSample: begin
        dark_d  = adc;
        state_d = StRedSettle;
        cnt_d   = settle_init;
      end
`endif
      StRedSettle: begin
        if (cnt_q == '0) state_d = StRedSample;
        else cnt_d = cnt_q - SETTLE_W'(1);
      end
      StRedSample: begin
        red_d   = sample_val;
        load    = 1'b1;
        load_ch = CH_RED;
        state_d = StRedPush;
      end
      StRedPush: begin
        if (push_done) begin
          state_d = StIrSettle;
          cnt_d   = settle_init;
        end
      end
      StIrSettle: begin
        if (cnt_q == '0) state_d = StIrSample;
        else cnt_d = cnt_q - SETTLE_W'(1);
      end
      StIrSample: begin
        ir_d    = sample_val;
        load    = 1'b1;
        load_ch = CH_IR;
        state_d = StIrPush;
      end
      StIrPush: begin
        if (push_done) begin
          frame_done_d = 1'b1;
          if (enable) begin
            state_d = FrameStart;
            cnt_d   = settle_init;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      red_q        <= '0;
      ir_q         <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      red_q        <= red_d;
      ir_q         <= ir_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef DARK_PHASE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dark_q <= '0;
    else dark_q <= dark_d;
  end
`endif

  ppg_sample_pusher #(
    .MaxWait(MAX_WAIT)
  ) u_pusher (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .load_data_i(sample_val),
    .load_ch_i  (load_ch),
    .fir_ready_i(fir_ready),
    .fir_valid_o(fir_valid),
    .fir_data_o (fir_data),
    .fir_ch_o   (fir_ch),
    .done_o     (push_done),
    .drop_o     (push_drop)
  );

  assign led_red    = (state_q == StRedSettle) || (state_q == StRedSample);
  assign led_ir     = (state_q == StIrSettle) || (state_q == StIrSample);
  assign red_sample = red_q;
  assign ir_sample  = ir_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_led_adc_scheduler.sv
// Directed bench for led_adc_scheduler with a scoreboard of expected FIR pushes.
module tb_led_adc_scheduler;
  import ppg_pkg::*;

  localparam int unsigned MaxWait = 8;
`ifdef DARK_PHASE_EN
  localparam bit Dark = 1'b1;
`else
  localparam bit Dark = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, enable, fir_ready;
  logic [3:0] settle_cycles;
  logic [7:0] adc;
  logic       led_red, led_ir, fir_valid, fir_ch, frame_done, overrun;
  logic [7:0] fir_data, red_sample, ir_sample;

  always #5 clk = ~clk;

  led_adc_scheduler #(
    .MAX_WAIT(MaxWait)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .settle_cycles(settle_cycles),
    .adc          (adc),
    .fir_ready    (fir_ready),
    .led_red      (led_red),
    .led_ir       (led_ir),
    .fir_valid    (fir_valid),
    .fir_data     (fir_data),
    .fir_ch       (fir_ch),
    .red_sample   (red_sample),
    .ir_sample    (ir_sample),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] sb_q[$];
  logic [7:0] red_val, ir_val, dark_val, prev_data;
  bit   ready_base, chk_period;
  bit   prev_red, prev_ir, prev_valid, prev_rdy, prev_ch;
  int   stall_left, cyc, red_run, valid_run, last_valid_run, first_valid_run;
  int   last_fd_cyc, n_xfer, n_drop, n_frames;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_val(input logic [7:0] v);
    if (Dark) return (v > dark_val) ? v - dark_val : 8'h00;
    return v;
  endfunction

  function automatic int eff_settle();
    return (settle_cycles == 4'd0) ? 1 : int'(settle_cycles);
  endfunction

  function automatic int exp_period();
    return 2 * (eff_settle() + 2) + (Dark ? eff_settle() + 1 : 0);
  endfunction

  task automatic clear_tb();
    sb_q.delete();
    last_fd_cyc = -1; red_run = 0; valid_run = 0; last_valid_run = 0;
    first_valid_run = -1; n_xfer = 0; n_drop = 0; n_frames = 0; stall_left = 0;
    prev_red = 0; prev_ir = 0; prev_valid = 0; prev_rdy = 0; prev_ch = 0;
    prev_data = 8'h00;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_led_red"}, 32'(led_red), 0);
    chk({tag, "_led_ir"}, 32'(led_ir), 0);
    chk({tag, "_fir_valid"}, 32'(fir_valid), 0);
    chk({tag, "_fir_ch"}, 32'(fir_ch), 0);
    chk({tag, "_fir_data"}, 32'(fir_data), 0);
    chk({tag, "_red_sample"}, 32'(red_sample), 0);
    chk({tag, "_ir_sample"}, 32'(ir_sample), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_tb();
  endtask

  // One clock: drive inputs at the falling edge, then observe and score.
  task automatic step();
    logic [8:0] e;
    @(negedge clk);
    cyc++;
    adc = led_red ? red_val : (led_ir ? ir_val : dark_val);
    if (fir_valid && stall_left > 0) begin
      fir_ready = 1'b0;
      stall_left--;
    end else begin
      fir_ready = ready_base;
    end
    chk("led_excl", 32'(led_red & led_ir), 0);
    if (led_red && !prev_red) sb_q.push_back({CH_RED, exp_val(red_val)});
    if (led_ir && !prev_ir) sb_q.push_back({CH_IR, exp_val(ir_val)});
    if (led_red) red_run++;
    else if (prev_red) begin
      chk("red_len", 32'(red_run), 32'(eff_settle() + 1));
      red_run = 0;
    end
    if (prev_valid && !prev_rdy && fir_valid) begin
      chk("stable_data", 32'(fir_data), 32'(prev_data));
      chk("stable_ch", 32'(fir_ch), 32'(prev_ch));
    end
    if (fir_valid && fir_ready) begin
      n_xfer++;
      chk("sb_avail", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("fir_ch", 32'(fir_ch), 32'(e[8]));
        chk("fir_data", 32'(fir_data), 32'(e[7:0]));
        chk("held_sample", 32'(fir_ch ? ir_sample : red_sample), 32'(e[7:0]));
      end
    end
    if (prev_valid && !prev_rdy && !fir_valid) begin
      n_drop++;
      if (sb_q.size() > 0) e = sb_q.pop_front();
    end
    if (fir_valid) valid_run++;
    else if (prev_valid) begin
      last_valid_run = valid_run;
      if (first_valid_run < 0) first_valid_run = valid_run;
      valid_run = 0;
    end
    if (frame_done) begin
      n_frames++;
      if (chk_period && last_fd_cyc >= 0) chk("frame_period", 32'(cyc - last_fd_cyc), 32'(exp_period()));
      last_fd_cyc = cyc;
    end
    prev_red = led_red; prev_ir = led_ir; prev_valid = fir_valid; prev_rdy = fir_ready;
    prev_data = fir_data; prev_ch = fir_ch;
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b0; settle_cycles = 4'd2; adc = 8'h00; fir_ready = 1'b0;
    red_val = 8'h40; ir_val = 8'h80; dark_val = 8'h00; ready_base = 1'b1; chk_period = 1'b1;
    cyc = 0;
    clear_tb();
    #2 rst_n = 1'b0;
    #1 chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle holds with enable low
    repeat (4) step();
    chk("idle_led", 32'(led_red | led_ir | fir_valid), 0);

    // Basic frame with settle=2
    enable = 1'b1;
    repeat (45) step();
    chk("t1_frames", 32'(n_frames >= 4), 1);
    chk("t1_overrun", 32'(overrun), 0);

    // settle=0 behaves as 1
    do_reset();
    settle_cycles = 4'd0;
    enable = 1'b1;
    repeat (30) step();
    chk("t2_frames", 32'(n_frames >= 4), 1);

    // Five-clock stall in RED_PUSH, then accepted
    do_reset();
    settle_cycles = 4'd1; chk_period = 1'b0; stall_left = 5;
    enable = 1'b1;
    for (int i = 0; i < 60 && n_xfer < 2; i++) step();
    chk("t3_xfers", 32'(n_xfer), 2);
    chk("t3_valid_len", 32'(first_valid_run), 6);
    chk("t3_drop", 32'(n_drop), 0);
    chk("t3_overrun", 32'(overrun), 0);

    // fir_ready stuck low: drop after MAX_WAIT clocks
    do_reset();
    ready_base = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 60 && n_drop < 1; i++) step();
    chk("t4_drop_seen", 32'(n_drop), 1);
    chk("t4_valid_len", 32'(last_valid_run), MaxWait);
    chk("t4_valid_low", 32'(fir_valid), 0);
    chk("t4_overrun", 32'(overrun), 1);
    chk("t4_ir_settle", 32'(led_ir), 1);
    ready_base = 1'b1;
    repeat (20) step();
    chk("t4_overrun_sticky", 32'(overrun), 1);

    // Reset during IR_SETTLE, then stop at frame end
    do_reset();
    settle_cycles = 4'd3; chk_period = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 40 && !led_ir; i++) step();
    chk("t5_in_ir", 32'(led_ir), 1);
    #1 rst_n = 1'b0;
    #1 chk_reset("t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    clear_tb();
    for (int i = 0; i < 60 && n_frames < 1; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 60 && n_frames < 2; i++) step();
    chk("t5_frames", 32'(n_frames), 2);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t5_idle", 32'(led_red | led_ir | fir_valid), 0);
    end
    chk("t5_sb_empty", 32'(sb_q.size()), 0);

    // Ambient subtraction (raw values when dark phase absent)
    do_reset();
    settle_cycles = 4'd1;
    red_val = 8'h08; ir_val = 8'h50; dark_val = 8'h10;
    enable = 1'b1;
    for (int i = 0; i < 60 && n_frames < 2; i++) step();
    chk("t6_frames", 32'(n_frames), 2);
    chk("t6_red_sample", 32'(red_sample), 32'(exp_val(8'h08)));
    chk("t6_ir_sample", 32'(ir_sample), 32'(exp_val(8'h50)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
